// File: rtl/reg_display_sequencer.sv
// Register-dump overlay sequencer.
// Reads NUM_REGS registers one at a time and latches each 32-bit value into a shadow.
// Each register becomes the 12-character line "Rn: hhhhhhhh".
// The characters go one per transfer to the glyph plotter over a valid/ready handshake.
module reg_display_sequencer #(
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned AUTO_REFRESH = 0,
  parameter logic [7:0]  CHAR_R       = 8'd52,
  parameter logic [7:0]  CHAR_COLON   = 8'd17,
  parameter logic [7:0]  CHAR_SPACE   = 8'd18
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [31:0]       register_value,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_code,
  output logic [3:0]        char_col,
  output logic [3:0]        char_row,
  output logic              finished_register,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StCapture,
    StEmit,
    StNext
  } state_e;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [3:0]        LAST_COL  = 4'd11;
  localparam logic [2:0]        WAIT_LOAD = 3'(READ_LAT - 1);

  state_e      state;
  logic [3:0]  idx;
  logic [2:0]  wait_cnt;
  logic [31:0] shadow;

  logic [3:0]  next_col;
  logic [7:0]  next_code;
  logic [31:0] shifted;

  // Register-file address of register i, wrapping to the bus width.
  function automatic logic [ADDR_W-1:0] reg_addr(input logic [3:0] i);
    return BASE + ADDR_W'(i);
  endfunction

  // Glyph for the column that follows the one currently presented.
  always_comb begin
    next_col  = char_col + 4'd1;
    shifted   = shadow >> {(LAST_COL - next_col), 2'b00};
    next_code = 8'd0;
    case (next_col)
      4'd0:    next_code = CHAR_R;
      4'd1:    next_code = {4'h0, idx};
      4'd2:    next_code = CHAR_COLON;
      4'd3:    next_code = CHAR_SPACE;
      default: next_code = {4'h0, shifted[3:0]};
    endcase
  end

  // Sequencer FSM; every output is a register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state             <= StIdle;
      idx               <= 4'd0;
      wait_cnt          <= 3'd0;
      shadow            <= 32'd0;
      addr              <= BASE;
      char_valid        <= 1'b0;
      char_code         <= 8'd0;
      char_col          <= 4'd0;
      char_row          <= 4'd0;
      finished_register <= 1'b0;
      frame_done        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      finished_register <= 1'b0;
      frame_done        <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            idx   <= 4'd0;
            addr  <= reg_addr(4'd0);
            busy  <= 1'b1;
            state <= StAddr;
          end
        end
        StAddr: begin
          // ADDR itself is one read-latency cycle, so WAIT only covers the rest.
          wait_cnt <= WAIT_LOAD;
          state    <= (READ_LAT > 1) ? StWait : StCapture;
        end
        StWait: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= StCapture;
          end
        end
        StCapture: begin
          // The shadow freezes the value so later read-data changes cannot tear the line.
          shadow     <= register_value;
          char_col   <= 4'd0;
          char_row   <= idx;
          char_code  <= CHAR_R;
          char_valid <= 1'b1;
          state      <= StEmit;
        end
        StEmit: begin
          if (char_ready) begin
            if (char_col == LAST_COL) begin
              char_valid        <= 1'b0;
              finished_register <= 1'b1;
              frame_done        <= (idx == LAST_IDX);
              state             <= StNext;
            end else begin
              char_col  <= next_col;
              char_code <= next_code;
            end
          end
        end
        StNext: begin
          if (idx == LAST_IDX) begin
            if (AUTO_REFRESH != 0) begin
              idx   <= 4'd0;
              addr  <= reg_addr(4'd0);
              state <= StAddr;
            end else begin
              busy  <= 1'b0;
              state <= StIdle;
            end
          end else begin
            idx   <= idx + 4'd1;
            addr  <= reg_addr(idx + 4'd1);
            state <= StAddr;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/reg_display_sequencer.md
Name: reg_display_sequencer

Overview:
- Sequences the register-dump overlay.
- Walks the register file one register at a time and latches each 32-bit value.
- Turns each register into a 12-character text line, "R", index hex digit, ":", space, then 8 hex nibbles MSB first.
- Hands the characters one at a time to the 8x8 glyph plotter over a valid/ready handshake, and signals when each register line and each full frame are finished.

Parameters:
NUM_REGS, 8, registers displayed per frame (1..16); one display row per register.
ADDR_W, 9, width of the register-file address bus.
BASE_ADDR, 0, address of register 0; register i is at BASE_ADDR+i.
READ_LAT, 1, cycles from addr change to register_value valid (1..4).
AUTO_REFRESH, 0, 1 = restart a new frame automatically after frame_done.
CHAR_R, 52, glyph code for 'R'.
CHAR_COLON, 17, glyph code for ':'.
CHAR_SPACE, 18, glyph code for blank.

Ports:
clock  in  1  system clock; every sequential element is clocked on its rising edge.
resetn  in  1  asynchronous, active-low reset.
start  in  1  begin a frame; sampled only in IDLE.
addr  out  ADDR_W  register-file read address.
register_value  in  32  read data, valid READ_LAT cycles after addr.
char_valid  out  1  character request valid.
char_ready  in  1  plotter accepts the current character.
char_code  out  8  glyph code: 0-15 for hex digits, otherwise CHAR_*.
char_col  out  4  column 0..11 within the line.
char_row  out  4  row = register index.
finished_register  out  1  one-cycle pulse when a register's 12th character is accepted.
frame_done  out  1  one-cycle pulse when the last register completes.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0, addr = BASE_ADDR, state IDLE.
  - Reset is honoured mid-operation: it aborts immediately, and the next frame starts again at register 0.
- States: IDLE, ADDR, WAIT, CAPTURE, EMIT, NEXT.
- IDLE
  - start=1 at edge k: idx<=0, go to ADDR.
  - start while busy is ignored (not queued).
- ADDR
  - addr = BASE_ADDR+idx; addr is driven from cycle k+1 and held until the next ADDR.
  - A wait counter loads READ_LAT-1 and the state moves to WAIT.
- WAIT
  - Counts down; at 0 moves to CAPTURE.
  - Net effect: register_value is sampled exactly READ_LAT cycles after addr changed.
- CAPTURE
  - Latches register_value into a 32-bit shadow, col<=0, goes to EMIT.
  - Changes on register_value after the capture edge must not affect the line being drawn (no tearing).
- EMIT: char_valid=1, char_row=idx, char_col=col.
  - char_code by column: col0 CHAR_R; col1 idx[3:0]; col2 CHAR_COLON; col3 CHAR_SPACE.
  - col4..11: shadow nibble [31-4(col-4) -: 4], zero-extended to 8 bits.
  - A transfer happens on an edge where char_valid and char_ready are both 1.
  - code, col and row stay stable while valid=1 and ready=0; valid is never dropped before a transfer.
  - On a transfer with col<11: col++, and char_valid stays high next cycle, so back-to-back transfers are allowed (one character per cycle when ready is held high).
  - On a transfer with col==11: finished_register pulses next cycle, char_valid drops, go to NEXT.
- NEXT
  - If idx==NUM_REGS-1: frame_done pulses in the same cycle as finished_register.
    - AUTO_REFRESH=0: go to IDLE.
    - AUTO_REFRESH=1: idx<=0 and go to ADDR.
  - Otherwise: idx++ and go to ADDR.
- Width rules
  - idx is 4 bits; addr = BASE_ADDR + idx truncated to ADDR_W.
  - col wraps only by explicit reset to 0 in CAPTURE; the 4-bit counter never runs past 11.
- Minimum cost per register with ready held high: 1 (ADDR) + READ_LAT-1 (WAIT) + 1 (CAPTURE) + 12 (EMIT) + 1 (NEXT) = 14+READ_LAT cycles.
- busy is high from the cycle after start is accepted until the cycle IDLE is re-entered.

Test Plan:
- Basic line: NUM_REGS=1, READ_LAT=1, reg0=32'h1234ABCD, ready held 1, pulse start.
  - Required: 12 consecutive transfers with codes 52,0,17,18,1,2,3,4,10,11,12,13 on cols 0..11, row 0.
  - Then finished_register and frame_done pulse once each, busy falls.
- Backpressure: ready low for 5 cycles during col 6.
  - Required: char_code/col/row held constant at 3/6 (for 1234ABCD), no duplicate or skipped characters.
- Latency and tearing: READ_LAT=3, register_value changes to 32'hFFFFFFFF one cycle after capture.
  - Required: the displayed nibbles are the value present exactly 3 cycles after addr changed, not FFFFFFFF.
- Full frame: NUM_REGS=8, BASE_ADDR=16, reg i = i*32'h11111111.
  - Required: addr steps 16..23; row i shows 'R', i, ':', ' ', then eight copies of digit i.
  - Required: 8 finished_register pulses and 1 frame_done pulse.
- Control: start while busy is ignored; AUTO_REFRESH=1 restarts at addr=BASE_ADDR the cycle after frame_done.
  - resetn low mid-EMIT: all outputs 0 immediately (asynchronously); the next start begins at row 0, col 0.
